// File: rtl/pipe_scheduler_pkg.sv
// Shared definitions for the pipe scheduler: FSM state encoding, pipe count
// and the Galois LFSR step used to pick fresh gap positions.
package pipe_scheduler_pkg;

    localparam int NUM_PIPES = 3;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_UPD1   = 3'd2,
        ST_UPD2   = 3'd3,
        ST_UPD3   = 3'd4,
        ST_COMMIT = 3'd5,
        ST_HALTED = 3'd6
    } state_e;

    // Right-shifting Galois step; the taps are folded in when bit 0 falls out.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/pipe_scheduler_if.sv
// Control and pipe-layout bundle between the game FSM / renderer (master)
// and the pipe scheduler (slave).
interface pipe_scheduler_if;

    logic               frame_tick;
    logic               start;
    logic               halt;
    logic signed [15:0] pos_x1;
    logic signed [15:0] pos_x2;
    logic signed [15:0] pos_x3;
    logic signed [15:0] pos_y1;
    logic signed [15:0] pos_y2;
    logic signed [15:0] pos_y3;
    logic               score_pulse;
    logic               running;
    logic               busy;

    modport master (
        output frame_tick, start, halt,
        input  pos_x1, pos_x2, pos_x3, pos_y1, pos_y2, pos_y3,
        input  score_pulse, running, busy
    );

    modport slave (
        input  frame_tick, start, halt,
        output pos_x1, pos_x2, pos_x3, pos_y1, pos_y2, pos_y3,
        output score_pulse, running, busy
    );

endinterface

// File: rtl/pipe_lfsr.sv
// 16-bit Galois LFSR that only advances when asked; next_value is exposed
// so the recycled gap can use the post-step value in the same cycle.
module pipe_lfsr
    import pipe_scheduler_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    output logic [15:0] value,
    output logic [15:0] next_value
);

    assign next_value = lfsr_step(value);

    // LFSR state: seeded on reset only, stepped on each recycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= SEED;
        end else if (step) begin
            value <= next_value;
        end else begin
            value <= value;
        end
    end

endmodule

// File: rtl/pipe_scheduler.sv
// Scrolls the three pipes once per frame through a shared one-pipe-per-cycle
// datapath, recycles exited pipes with a random gap and commits all at once.
module pipe_scheduler
    import pipe_scheduler_pkg::*;
#(
    parameter logic signed [15:0] SPAWN_Y     = 16'sd480,
    parameter logic signed [15:0] SPACING     = 16'sd240,
    parameter logic signed [15:0] PIPE_W      = 16'sd104,
    parameter logic signed [15:0] SCROLL_STEP = 16'sd2,
    parameter logic signed [15:0] BIRD_Y      = 16'sd128,
    parameter logic signed [15:0] GAP_MIN     = 16'sd64,
    parameter logic signed [15:0] GAP_INIT    = 16'sd160,
    parameter logic [15:0]        LFSR_SEED   = 16'hACE1
) (
    input  logic                clk,
    input  logic                rst,
    pipe_scheduler_if.slave     bus
);

    localparam logic signed [15:0] WRAP_Y     = SPACING + SPACING + SPACING;
    localparam logic signed [15:0] NEG_PIPE_W = -PIPE_W;
    localparam logic signed [15:0] INIT_Y [NUM_PIPES] =
        '{SPAWN_Y, SPAWN_Y + SPACING, SPAWN_Y + SPACING + SPACING};

    state_e             state_r;
    logic signed [15:0] pos_x_r    [NUM_PIPES];
    logic signed [15:0] pos_y_r    [NUM_PIPES];
    logic signed [15:0] shadow_x_r [NUM_PIPES];
    logic signed [15:0] shadow_y_r [NUM_PIPES];
    logic [NUM_PIPES-1:0] flag_r;
    logic               score_pulse_r;
    logic               running_r;
    logic               busy_r;

    logic [1:0]         sel_s;
    logic               upd_s;
    logic signed [15:0] cur_y_s;
    logic signed [15:0] cur_x_s;
    logic signed [15:0] ny_raw_s;
    logic signed [15:0] ny_s;
    logic signed [15:0] gx_s;
    logic signed [15:0] gap_off_s;
    logic               recycle_s;
    logic               score_s;
    logic               step_s;
    logic [15:0]        lfsr_next_s;

    // Which pipe the shared datapath serves this cycle.
    always_comb begin
        sel_s = 2'd0;
        upd_s = 1'b0;
        case (state_r)
            ST_UPD1: begin sel_s = 2'd0; upd_s = 1'b1; end
            ST_UPD2: begin sel_s = 2'd1; upd_s = 1'b1; end
            ST_UPD3: begin sel_s = 2'd2; upd_s = 1'b1; end
            default: begin sel_s = 2'd0; upd_s = 1'b0; end
        endcase
    end

    // Shared scroll/recycle/score datapath; score is judged before the wrap.
    always_comb begin
        cur_y_s   = pos_y_r[sel_s];
        cur_x_s   = pos_x_r[sel_s];
        ny_raw_s  = cur_y_s - SCROLL_STEP;
        recycle_s = (ny_raw_s <= NEG_PIPE_W);
        score_s   = ((cur_y_s + PIPE_W) > BIRD_Y) && ((ny_raw_s + PIPE_W) <= BIRD_Y);
        gap_off_s = $signed(lfsr_next_s & 16'h00FF);
        if (recycle_s) begin
            ny_s = ny_raw_s + WRAP_Y;
            gx_s = GAP_MIN + gap_off_s;
        end else begin
            ny_s = ny_raw_s;
            gx_s = cur_x_s;
        end
    end

    // A halted update must not consume LFSR entropy.
    assign step_s = upd_s && recycle_s && !bus.halt;

    pipe_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk        (clk),
        .rst        (rst),
        .step       (step_s),
        .value      (),
        .next_value (lfsr_next_s)
    );

    // Scheduler FSM with shadow registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            pos_y_r       <= INIT_Y;
            pos_x_r       <= '{default: GAP_INIT};
            shadow_y_r    <= INIT_Y;
            shadow_x_r    <= '{default: GAP_INIT};
            flag_r        <= '0;
            score_pulse_r <= 1'b0;
            running_r     <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            score_pulse_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_HALTED: begin
                    if (bus.start) begin
                        state_r   <= ST_RUN;
                        pos_y_r   <= INIT_Y;
                        pos_x_r   <= '{default: GAP_INIT};
                        running_r <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bus.halt) begin
                        state_r   <= ST_HALTED;
                        running_r <= 1'b0;
                    end else if (bus.frame_tick) begin
                        state_r <= ST_UPD1;
                        busy_r  <= 1'b1;
                    end
                end
                ST_UPD1, ST_UPD2, ST_UPD3: begin
                    if (bus.halt) begin
                        state_r   <= ST_HALTED;
                        running_r <= 1'b0;
                        busy_r    <= 1'b0;
                    end else begin
                        shadow_y_r[sel_s] <= ny_s;
                        shadow_x_r[sel_s] <= gx_s;
                        flag_r[sel_s]     <= score_s;
                        state_r <= (state_r == ST_UPD1) ? ST_UPD2 :
                                   ((state_r == ST_UPD2) ? ST_UPD3 : ST_COMMIT);
                    end
                end
                ST_COMMIT: begin
                    busy_r <= 1'b0;
                    if (bus.halt) begin
                        state_r   <= ST_HALTED;
                        running_r <= 1'b0;
                    end else begin
                        pos_y_r       <= shadow_y_r;
                        pos_x_r       <= shadow_x_r;
                        score_pulse_r <= |flag_r;
                        state_r       <= ST_RUN;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    running_r <= 1'b0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pos_x1      = pos_x_r[0];
    assign bus.pos_x2      = pos_x_r[1];
    assign bus.pos_x3      = pos_x_r[2];
    assign bus.pos_y1      = pos_y_r[0];
    assign bus.pos_y2      = pos_y_r[1];
    assign bus.pos_y3      = pos_y_r[2];
    assign bus.score_pulse = score_pulse_r;
    assign bus.running     = running_r;
    assign bus.busy        = busy_r;

endmodule

// File: tb/tb_pipe_scheduler.sv
// Self-checking bench for pipe_scheduler: a per-frame reference model of the
// pipe layout, randomized tick spacing and halt placement.
module tb_pipe_scheduler;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_scheduler_if bus ();
    pipe_scheduler dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_errors = 0;
    int my [3];
    int mx [3];
    logic [15:0] mlfsr;
    int ticks_done;

    function automatic logic [15:0] ref_lfsr_next(input logic [15:0] v);
        logic [15:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    function automatic void model_layout();
        my = '{480, 720, 960};
        mx = '{160, 160, 160};
    endfunction

    // One frame of the game rules; returns whether any pipe passed the bird.
    function automatic bit model_tick();
        bit sc;
        sc = 1'b0;
        for (int k = 0; k < 3; k++) begin
            int ny;
            ny = my[k] - 2;
            if ((my[k] + 104 > 128) && (ny + 104 <= 128)) sc = 1'b1;
            if (ny <= -104) begin
                ny = ny + 720;
                mlfsr = ref_lfsr_next(mlfsr);
                mx[k] = 64 + int'(mlfsr[7:0]);
            end
            my[k] = ny;
        end
        return sc;
    endfunction

    function automatic logic [95:0] exp_pos();
        return {16'(my[0]), 16'(my[1]), 16'(my[2]), 16'(mx[0]), 16'(mx[1]), 16'(mx[2])};
    endfunction

    function automatic logic [95:0] act_pos();
        return {bus.pos_y1, bus.pos_y2, bus.pos_y3, bus.pos_x1, bus.pos_x2, bus.pos_x3};
    endfunction

    // Drive one tick, observe the 4-cycle window plus the pulse cycle, then idle a little.
    task automatic tick_cycle(output bit pulse, output logic [95:0] pos);
        @(negedge clk) bus.frame_tick = 1'b1;
        @(negedge clk) bus.frame_tick = 1'b0;
        pulse = 1'b0;
        repeat (4) begin
            @(negedge clk);
            pulse = pulse | bus.score_pulse;
        end
        pos = act_pos();
        repeat ($urandom_range(0, 3)) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
    endtask

    task automatic test_reset();
        logic [95:0] lay;
        bit p;
        logic [95:0] pos;
        lay = {16'd480, 16'd720, 16'd960, 16'd160, 16'd160, 16'd160};
        rst = 1'b1;
        bus.frame_tick = 1'b0; bus.start = 1'b0; bus.halt = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        mlfsr = 16'hACE1;
        model_layout();
        n_checks++; if (act_pos() !== lay) begin n_errors++; $display("FAIL reset_pos: got %h want %h", act_pos(), lay); end
        n_checks++; if ({bus.score_pulse, bus.running, bus.busy} !== 3'b000) begin n_errors++; $display("FAIL reset_flags: got %b want 000", {bus.score_pulse, bus.running, bus.busy}); end
        n_checks++; if (dut.u_lfsr.value !== 16'hACE1) begin n_errors++; $display("FAIL reset_lfsr: got %h want ace1", dut.u_lfsr.value); end
        tick_cycle(p, pos);
        n_checks++; if (pos !== lay || bus.busy !== 1'b0) begin n_errors++; $display("FAIL idle_tick: pos %h busy %b want %h busy 0", pos, bus.busy, lay); end
    endtask

    task automatic test_first_tick();
        logic [95:0] old_p, new_p, first;
        bit sc;
        first = {16'd478, 16'd718, 16'd958, 16'd160, 16'd160, 16'd160};
        pulse_start();
        n_checks++; if (bus.running !== 1'b1) begin n_errors++; $display("FAIL start_running: got %b want 1", bus.running); end
        old_p = exp_pos();
        sc = model_tick();
        ticks_done = 1;
        new_p = exp_pos();
        @(negedge clk) bus.frame_tick = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            bus.frame_tick = 1'b0;
            n_checks++; if (bus.busy !== 1'(c <= 4)) begin n_errors++; $display("FAIL busy_cycle%0d: got %b want %b", c, bus.busy, c <= 4); end
            if (c == 4) begin
                n_checks++; if (act_pos() !== old_p) begin n_errors++; $display("FAIL early_commit: got %h want %h", act_pos(), old_p); end
            end
            if (c == 5) begin
                n_checks++; if (act_pos() !== new_p) begin n_errors++; $display("FAIL first_commit: got %h want %h", act_pos(), new_p); end
                n_checks++; if (act_pos() !== first) begin n_errors++; $display("FAIL first_layout: got %h want %h", act_pos(), first); end
                n_checks++; if (bus.score_pulse !== sc) begin n_errors++; $display("FAIL first_score: got %b want %b", bus.score_pulse, sc); end
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_score();
        int first_pulse, pulses;
        bit sc, p;
        logic [95:0] pos;
        first_pulse = -1;
        pulses = 0;
        while (ticks_done < 292) begin
            sc = model_tick();
            ticks_done++;
            tick_cycle(p, pos);
            n_checks++; if (p !== sc) begin n_errors++; $display("FAIL score_tick%0d: got %b want %b", ticks_done, p, sc); end
            n_checks++; if (pos !== exp_pos()) begin n_errors++; $display("FAIL pos_tick%0d: got %h want %h", ticks_done, pos, exp_pos()); end
            if (p) begin
                pulses++;
                if (first_pulse < 0) first_pulse = ticks_done;
            end
        end
        n_checks++; if (first_pulse != 228 || pulses != 1) begin n_errors++; $display("FAIL score_when: first %0d count %0d want 228 and 1", first_pulse, pulses); end
    endtask

    task automatic test_recycle();
        n_checks++; if (bus.pos_y1 !== 16'sd616 || bus.pos_x1 !== 16'sd176) begin n_errors++; $display("FAIL recycle_p1: y %0d x %0d want 616 176", bus.pos_y1, bus.pos_x1); end
        n_checks++; if (bus.pos_y2 !== 16'sd136 || bus.pos_y3 !== 16'sd376) begin n_errors++; $display("FAIL recycle_p23: y2 %0d y3 %0d want 136 376", bus.pos_y2, bus.pos_y3); end
        n_checks++; if (dut.u_lfsr.value !== 16'hE270) begin n_errors++; $display("FAIL recycle_lfsr: got %h want e270", dut.u_lfsr.value); end
    endtask

    task automatic test_halt();
        logic [95:0] frozen, pos;
        bit p;
        frozen = exp_pos();
        @(negedge clk) bus.frame_tick = 1'b1;
        @(negedge clk) bus.frame_tick = 1'b0;
        @(negedge clk) bus.halt = 1'b1;
        @(negedge clk) bus.halt = 1'b0;
        n_checks++; if (bus.running !== 1'b0 || bus.busy !== 1'b0) begin n_errors++; $display("FAIL halt_state: running %b busy %b want 0 0", bus.running, bus.busy); end
        repeat (4) @(negedge clk);
        n_checks++; if (act_pos() !== frozen) begin n_errors++; $display("FAIL halt_nocommit: got %h want %h", act_pos(), frozen); end
        for (int i = 0; i < 10; i++) begin
            tick_cycle(p, pos);
            n_checks++; if (pos !== frozen || p !== 1'b0) begin n_errors++; $display("FAIL halted_tick%0d: pos %h pulse %b want %h 0", i, pos, p, frozen); end
        end
    endtask

    task automatic test_restart();
        logic [95:0] lay;
        lay = {16'd480, 16'd720, 16'd960, 16'd160, 16'd160, 16'd160};
        @(negedge clk) begin bus.start = 1'b1; bus.halt = 1'b1; end
        @(negedge clk) begin bus.start = 1'b0; bus.halt = 1'b0; end
        model_layout();
        n_checks++; if (bus.running !== 1'b1) begin n_errors++; $display("FAIL restart_running: got %b want 1", bus.running); end
        n_checks++; if (act_pos() !== lay) begin n_errors++; $display("FAIL restart_layout: got %h want %h", act_pos(), lay); end
        n_checks++; if (dut.u_lfsr.value !== 16'hE270) begin n_errors++; $display("FAIL restart_lfsr: got %h want e270", dut.u_lfsr.value); end
        @(negedge clk) begin bus.halt = 1'b1; bus.frame_tick = 1'b1; end
        @(negedge clk) begin bus.halt = 1'b0; bus.frame_tick = 1'b0; end
        n_checks++; if (bus.running !== 1'b0 || bus.busy !== 1'b0) begin n_errors++; $display("FAIL halt_tick_same: running %b busy %b want 0 0", bus.running, bus.busy); end
        repeat (5) @(negedge clk);
        n_checks++; if (act_pos() !== lay) begin n_errors++; $display("FAIL halt_tick_pos: got %h want %h", act_pos(), lay); end
        pulse_start();
    endtask

    task automatic test_busy_ignore();
        int o;
        logic [95:0] want;
        bit sc;
        o = $urandom_range(1, 4);
        sc = model_tick();
        want = exp_pos();
        @(negedge clk) bus.frame_tick = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            bus.frame_tick = (c == o);
            if (c == 5) begin
                n_checks++; if (act_pos() !== want || bus.score_pulse !== sc) begin n_errors++; $display("FAIL busy_tick_commit(o=%0d): got %h want %h", o, act_pos(), want); end
            end
            if (c == 6) begin
                n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL busy_tick_queued(o=%0d): busy %b want 0", o, bus.busy); end
            end
        end
        bus.frame_tick = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++; if (act_pos() !== want) begin n_errors++; $display("FAIL busy_tick_extra(o=%0d): got %h want %h", o, act_pos(), want); end
    endtask

    task automatic test_random_halt();
        int n, o;
        bit sc, p;
        logic [95:0] pos, frozen;
        n = $urandom_range(3, 12);
        for (int i = 0; i < n; i++) begin
            sc = model_tick();
            tick_cycle(p, pos);
            n_checks++; if (pos !== exp_pos() || p !== sc) begin n_errors++; $display("FAIL rand_tick%0d: pos %h pulse %b want %h %b", i, pos, p, exp_pos(), sc); end
        end
        frozen = exp_pos();
        o = $urandom_range(1, 4);
        @(negedge clk) bus.frame_tick = 1'b1;
        for (int c = 1; c <= o; c++) begin
            @(negedge clk);
            bus.frame_tick = 1'b0;
            bus.halt = (c == o);
        end
        @(negedge clk) bus.halt = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (act_pos() !== frozen || bus.running !== 1'b0) begin n_errors++; $display("FAIL rand_halt(o=%0d): pos %h running %b want %h 0", o, act_pos(), bus.running, frozen); end
        pulse_start();
        model_layout();
    endtask

    task automatic test_rst_mid();
        logic [95:0] lay;
        lay = {16'd480, 16'd720, 16'd960, 16'd160, 16'd160, 16'd160};
        @(negedge clk) bus.frame_tick = 1'b1;
        @(negedge clk) bus.frame_tick = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        n_checks++; if (act_pos() !== lay || bus.busy !== 1'b0 || bus.running !== 1'b0) begin n_errors++; $display("FAIL rst_mid: pos %h busy %b running %b want %h 0 0", act_pos(), bus.busy, bus.running, lay); end
        n_checks++; if (dut.u_lfsr.value !== 16'hACE1) begin n_errors++; $display("FAIL rst_mid_lfsr: got %h want ace1", dut.u_lfsr.value); end
    endtask

    initial begin
        test_reset();
        test_first_tick();
        test_score();
        test_recycle();
        test_halt();
        test_restart();
        test_busy_ignore();
        test_random_halt();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
